stopwatch_counter: RTL

// - Stopwatch time base, fed by the 100 Hz centisecond tick from the clock divider.
// - Keeps an mm:ss.cc count in BCD, six 4-bit digits, range 00:00.00 .. 59:59.99.
// - Provides start/stop, lap (freeze display while counting continues) and clear.
// - Drives the seven-segment display mux directly.

---
 rtl/stopwatch_counter_pkg.sv | 53 +++++
 rtl/stopwatch_counter_digit.sv | 29 ++
 rtl/stopwatch_counter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/stopwatch_counter_pkg.sv
// Shared types, constants and the BCD step helper for the stopwatch time base.
// Imported by the digit counter and the stopwatch top level.
package stopwatch_counter_pkg;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] DEC_LIMIT     = 4'd9;
  localparam logic [BCD_W-1:0] MIN_LIMIT_DEF = 4'd5;
  localparam logic [BCD_W-1:0] SEC_LIMIT_DEF = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_PAUSED   = 3'd2,
    ST_LAP_RUN  = 3'd3,
    ST_LAP_HELD = 3'd4
  } sw_state_e;

  typedef struct packed {
    logic [BCD_W-1:0] m_tens;
    logic [BCD_W-1:0] m_ones;
    logic [BCD_W-1:0] s_tens;
    logic [BCD_W-1:0] s_ones;
    logic [BCD_W-1:0] c_tens;
    logic [BCD_W-1:0] c_ones;
  } bcd_time_t;

  localparam bcd_time_t BCD_ZERO = bcd_time_t'(24'd0);

  // Next value of one digit; clear wins over increment, and the wrap test uses
  // >= so a corrupted digit can never climb past its limit.
  function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] q,
                                                input logic             clr,
                                                input logic             inc,
                                                input logic [BCD_W-1:0] limit);
    if (clr) begin
      return 4'd0;
    end else if (inc) begin
      return (q >= limit) ? 4'd0 : (q + 4'd1);
    end else begin
      return q;
    end
  endfunction

  function automatic logic is_running(input sw_state_e st);
    return (st == ST_RUN) || (st == ST_LAP_RUN);
  endfunction

  function automatic logic is_lap(input sw_state_e st);
    return (st == ST_LAP_RUN) || (st == ST_LAP_HELD);
  endfunction

endpackage

// File: rtl/stopwatch_counter_digit.sv
// One BCD digit of the stopwatch carry chain: counts 0..limit on inc and
// signals carry in the same cycle it wraps back to zero.
module bcd_digit_counter
  import stopwatch_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [BCD_W-1:0] limit,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  logic [BCD_W-1:0] q_r;

  // Digit register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= 4'd0;
    end else begin
      q_r <= bcd_step(q_r, clr, inc, limit);
    end
  end

  assign q     = q_r;
  assign carry = inc & (q_r == limit);

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time base: run/pause/lap FSM, mm:ss.cc BCD carry chain, lap latch
// and the registered display feeding the seven-segment mux.
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter logic [3:0] MIN_LIMIT = MIN_LIMIT_DEF,
  parameter logic [3:0] SEC_LIMIT = SEC_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] m_tens,
  output logic [3:0] m_ones,
  output logic [3:0] s_tens,
  output logic [3:0] s_ones,
  output logic [3:0] c_tens,
  output logic [3:0] c_ones,
  output logic       running,
  output logic       lap_active,
  output logic       rollover
);

  sw_state_e state_r, state_nxt_s;
  logic      clear_go_s;
  logic      lap_latch_s;
  logic      advance_s;

  bcd_time_t live_s, live_nxt_s;
  bcd_time_t lap_r, lap_nxt_s;
  bcd_time_t disp_r, disp_nxt_s;

  logic running_r, lap_active_r, rollover_r;

  logic cy_c_ones_s, cy_c_tens_s, cy_s_ones_s, cy_s_tens_s, cy_m_ones_s, cy_m_tens_s;

  // Next-state decode; clear only acts from the two stopped states and then
  // masks any coincident start_stop/lap.
  always_comb begin
    state_nxt_s = state_r;
    clear_go_s  = 1'b0;
    lap_latch_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_stop) state_nxt_s = ST_RUN;
        else            state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (start_stop) begin
          state_nxt_s = ST_PAUSED;
        end else if (lap) begin
          state_nxt_s = ST_LAP_RUN;
          lap_latch_s = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_PAUSED: begin
        if (clear) begin
          state_nxt_s = ST_IDLE;
          clear_go_s  = 1'b1;
        end else if (start_stop) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PAUSED;
        end
      end
      ST_LAP_RUN: begin
        if (start_stop) state_nxt_s = ST_LAP_HELD;
        else if (lap)   state_nxt_s = ST_RUN;
        else            state_nxt_s = ST_LAP_RUN;
      end
      ST_LAP_HELD: begin
        if (clear) begin
          state_nxt_s = ST_IDLE;
          clear_go_s  = 1'b1;
        end else if (start_stop) begin
          state_nxt_s = ST_LAP_RUN;
        end else if (lap) begin
          state_nxt_s = ST_PAUSED;
        end else begin
          state_nxt_s = ST_LAP_HELD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  assign advance_s = tick & is_running(state_r);

  bcd_digit_counter u_c_ones (.clk(clk), .rst_n(rst_n), .clr(clear_go_s), .inc(advance_s),
                              .limit(DEC_LIMIT), .q(live_s.c_ones), .carry(cy_c_ones_s));
  bcd_digit_counter u_c_tens (.clk(clk), .rst_n(rst_n), .clr(clear_go_s), .inc(cy_c_ones_s),
                              .limit(DEC_LIMIT), .q(live_s.c_tens), .carry(cy_c_tens_s));
  bcd_digit_counter u_s_ones (.clk(clk), .rst_n(rst_n), .clr(clear_go_s), .inc(cy_c_tens_s),
                              .limit(DEC_LIMIT), .q(live_s.s_ones), .carry(cy_s_ones_s));
  bcd_digit_counter u_s_tens (.clk(clk), .rst_n(rst_n), .clr(clear_go_s), .inc(cy_s_ones_s),
                              .limit(SEC_LIMIT), .q(live_s.s_tens), .carry(cy_s_tens_s));
  bcd_digit_counter u_m_ones (.clk(clk), .rst_n(rst_n), .clr(clear_go_s), .inc(cy_s_tens_s),
                              .limit(DEC_LIMIT), .q(live_s.m_ones), .carry(cy_m_ones_s));
  bcd_digit_counter u_m_tens (.clk(clk), .rst_n(rst_n), .clr(clear_go_s), .inc(cy_m_ones_s),
                              .limit(MIN_LIMIT), .q(live_s.m_tens), .carry(cy_m_tens_s));

  // Look-ahead of the chain so the display shows a tick one clock after it,
  // and the lap freeze captures the count as it was before a coincident tick.
  always_comb begin
    live_nxt_s.c_ones = bcd_step(live_s.c_ones, clear_go_s, advance_s,   DEC_LIMIT);
    live_nxt_s.c_tens = bcd_step(live_s.c_tens, clear_go_s, cy_c_ones_s, DEC_LIMIT);
    live_nxt_s.s_ones = bcd_step(live_s.s_ones, clear_go_s, cy_c_tens_s, DEC_LIMIT);
    live_nxt_s.s_tens = bcd_step(live_s.s_tens, clear_go_s, cy_s_ones_s, SEC_LIMIT);
    live_nxt_s.m_ones = bcd_step(live_s.m_ones, clear_go_s, cy_s_tens_s, DEC_LIMIT);
    live_nxt_s.m_tens = bcd_step(live_s.m_tens, clear_go_s, cy_m_ones_s, MIN_LIMIT);

    if (clear_go_s) begin
      lap_nxt_s = BCD_ZERO;
    end else if (lap_latch_s) begin
      lap_nxt_s = live_s;
    end else begin
      lap_nxt_s = lap_r;
    end

    if (is_lap(state_nxt_s)) begin
      disp_nxt_s = lap_nxt_s;
    end else begin
      disp_nxt_s = live_nxt_s;
    end
  end

  // Lap latch, display and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_r        <= BCD_ZERO;
      disp_r       <= BCD_ZERO;
      running_r    <= 1'b0;
      lap_active_r <= 1'b0;
      rollover_r   <= 1'b0;
    end else begin
      lap_r        <= lap_nxt_s;
      disp_r       <= disp_nxt_s;
      running_r    <= is_running(state_nxt_s);
      lap_active_r <= is_lap(state_nxt_s);
      rollover_r   <= cy_m_tens_s;
    end
  end

  assign m_tens     = disp_r.m_tens;
  assign m_ones     = disp_r.m_ones;
  assign s_tens     = disp_r.s_tens;
  assign s_ones     = disp_r.s_ones;
  assign c_tens     = disp_r.c_tens;
  assign c_ones     = disp_r.c_ones;
  assign running    = running_r;
  assign lap_active = lap_active_r;
  assign rollover   = rollover_r;

endmodule
